multi_clkgen: RTL and testbench

// - Synthesizable N-channel programmable clock/pulse generator, driven from the single system clock.
// - Each channel has its own period, high-time and phase offset, all counted in clk cycles.
// - Config is shadow-buffered, so new settings apply only at period boundaries and never glitch.
// - Used to derive phase-related strobes/clocks for downstream blocks and benches.

---
 rtl/multi_clkgen.sv | 126 ++++++++++++
 tb/tb_multi_clkgen.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_clkgen.sv
// N-channel programmable clock/pulse generator running off the system clock.
// Each channel has a shadow-buffered period/high/phase config that only takes effect at period boundaries.
module multi_clkgen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       cfg_load,
    input  logic [NUM_CH*CNT_W-1:0] cfg_period,
    input  logic [NUM_CH*CNT_W-1:0] cfg_high,
    input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       period_stb,
    output logic [NUM_CH-1:0]       cfg_err
);

    typedef enum logic [1:0] {IDLE, PHASE, HIGH, LOW} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] phase;
    } cfg_t;

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam cfg_t             CFG_RST = '{period: CNT_W'(2), high: CNT_W'(1), phase: '0};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
        cfg_t             shadow_q, active_q, active_d, cfg_in;
        logic             out_q, out_d;
        logic             stb_q, stb_d;
        logic             err_q, err_d;

        assign cfg_in.period = cfg_period[c*CNT_W +: CNT_W];
        assign cfg_in.high   = cfg_high[c*CNT_W +: CNT_W];
        assign cfg_in.phase  = cfg_phase[c*CNT_W +: CNT_W];
        assign cnt_inc       = cnt_q + ONE;

        // In HIGH/LOW, cnt is the position within the current period; outputs
        // are decoded from the present state and registered, so they lag the
        // state by one edge except for the immediate stop on en=0.
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        always_comb begin
            state_d  = state_q;
            cnt_d    = cnt_q;
            active_d = active_q;
            err_d    = err_q;
            out_d    = 1'b0;
            stb_d    = 1'b0;
            if (!en[c]) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                out_d = (state_q == HIGH);
                stb_d = (state_q == HIGH || state_q == LOW) && (cnt_q == '0);
                unique case (state_q)
                    IDLE: begin
                        active_d = shadow_q;
                        if (shadow_q.period == '0) begin
                            err_d = 1'b1;
                        end else if (shadow_q.phase == '0) begin
                            state_d = (shadow_q.high != '0) ? HIGH : LOW;
                            cnt_d   = '0;
                        end else begin
                            state_d = PHASE;
                            cnt_d   = shadow_q.phase - ONE;
                        end
                    end
                    PHASE: begin
                        if (cnt_q == '0) state_d = (active_q.high != '0) ? HIGH : LOW;
                        else             cnt_d   = cnt_q - ONE;
                    end
                    HIGH, LOW: begin
                        if (cnt_q == active_q.period - ONE) begin
                            // Period boundary: the only point where a new config is adopted.
                            active_d = shadow_q;
                            cnt_d    = '0;
                            if (shadow_q.period == '0) begin
                                state_d = IDLE;
                                err_d   = 1'b1;
                            end else begin
                                state_d = (shadow_q.high != '0) ? HIGH : LOW;
                            end
                        end else begin
                            cnt_d   = cnt_inc;
                            state_d = (cnt_inc < active_q.high) ? HIGH : LOW;
                        end
                    end
                endcase
            end
            // A valid load wins over a same-cycle error set; the channel then restarts from IDLE.
            if (cfg_load[c] && cfg_in.period != '0) err_d = 1'b0;
        end

        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q  <= IDLE;
                cnt_q    <= '0;
                // NOTE: config registers are reset to a usable default so an enable without a prior load still runs.
                shadow_q <= CFG_RST;
                active_q <= CFG_RST;
                out_q    <= 1'b0;
                stb_q    <= 1'b0;
                err_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                active_q <= active_d;
                out_q    <= out_d;
                stb_q    <= stb_d;
                err_q    <= err_d;
                if (cfg_load[c]) shadow_q <= cfg_in;
            end
        end

        assign clk_out[c]    = out_q;
        assign period_stb[c] = stb_q;
        assign cfg_err[c]    = err_q;
    end

endmodule

// File: tb/tb_multi_clkgen.sv
// Directed bench for multi_clkgen: expected outputs are queued as each step is
// driven and compared against the DUT after the following clock edge.
module tb_multi_clkgen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       cfg_load;
    logic [NUM_CH*CNT_W-1:0] cfg_period;
    logic [NUM_CH*CNT_W-1:0] cfg_high;
    logic [NUM_CH*CNT_W-1:0] cfg_phase;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       period_stb;
    logic [NUM_CH-1:0]       cfg_err;

    multi_clkgen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_phase  (cfg_phase),
        .clk_out    (clk_out),
        .period_stb (period_stb),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] out;
        logic [3:0] stb;
        logic [3:0] err;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [3:0] ch0(input logic b);
        return {3'b000, b};
    endfunction

    task automatic compare();
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        assert (clk_out === e.out) else begin
            n_miss++;
            $error("FAIL %s clk_out: got %b want %b", e.tag, clk_out, e.out);
        end
        assert (period_stb === e.stb) else begin
            n_miss++;
            $error("FAIL %s period_stb: got %b want %b", e.tag, period_stb, e.stb);
        end
        assert (cfg_err === e.err) else begin
            n_miss++;
            $error("FAIL %s cfg_err: got %b want %b", e.tag, cfg_err, e.err);
        end
    endtask

    task automatic expect_now(input string tag, input logic [3:0] o, input logic [3:0] s,
                              input logic [3:0] e);
        sb.push_back('{tag: tag, out: o, stb: s, err: e});
        compare();
    endtask

    // Queue the expectation, let one posedge happen, compare at the negedge.
    task automatic cyc(input string tag, input logic [3:0] o, input logic [3:0] s,
                       input logic [3:0] e);
        sb.push_back('{tag: tag, out: o, stb: s, err: e});
        @(negedge clk);
        compare();
        cfg_load = '0;
    endtask

    task automatic set_cfg(input int c, input int p, input int h, input int ph);
        cfg_period[c*CNT_W +: CNT_W] = CNT_W'(p);
        cfg_high[c*CNT_W +: CNT_W]   = CNT_W'(h);
        cfg_phase[c*CNT_W +: CNT_W]  = CNT_W'(ph);
        cfg_load[c]                  = 1'b1;
    endtask

    initial begin
        logic [3:0] o, s;
        rst_n      = 1'b0;
        en         = '0;
        cfg_load   = '0;
        cfg_period = '0;
        cfg_high   = '0;
        cfg_phase  = '0;

        @(negedge clk);
        expect_now("reset", 4'h0, 4'h0, 4'h0);
        rst_n = 1'b1;
        cyc("post_reset", 4'h0, 4'h0, 4'h0);

        // Basic: period 10, high 1, phase 2 -> pulses at k+3, k+13, k+23.
        set_cfg(0, 10, 1, 2);
        cyc("basic_load", 4'h0, 4'h0, 4'h0);
        en = 4'h1;
        for (int i = 0; i < 24; i++) begin
            o = ch0(i == 3 || i == 13 || i == 23);
            cyc("basic", o, o, 4'h0);
        end
        en = 4'h0;
        cyc("basic_stop", 4'h0, 4'h0, 4'h0);

        // Odd duty: 5/3/0 -> 11100 from k+1.
        set_cfg(0, 5, 3, 0);
        cyc("duty_load", 4'h0, 4'h0, 4'h0);
        en = 4'h1;
        for (int i = 0; i < 15; i++)
            cyc("duty", ch0(i >= 1 && (i - 1) % 5 < 3), ch0(i >= 1 && (i - 1) % 5 == 0), 4'h0);
        en = 4'h0;
        cyc("duty_stop", 4'h0, 4'h0, 4'h0);

        // Glitch-free update: 8/4, load 4/1 mid-HIGH, then load 6/2 on a boundary edge.
        set_cfg(0, 8, 4, 0);
        cyc("upd_load", 4'h0, 4'h0, 4'h0);
        en = 4'h1;
        for (int i = 0; i < 25; i++) begin
            if (i == 2)  set_cfg(0, 4, 1, 0);
            if (i == 12) set_cfg(0, 6, 2, 0);
            if (i == 0) begin
                o = 4'h0; s = 4'h0;
            end else if (i <= 8) begin
                o = ch0(i - 1 < 4);       s = ch0(i == 1);
            end else if (i <= 16) begin
                o = ch0((i - 9) % 4 == 0); s = o;
            end else begin
                o = ch0((i - 17) % 6 < 2); s = ch0((i - 17) % 6 == 0);
            end
            cyc("update", o, s, 4'h0);
        end
        en = 4'h0;
        cyc("upd_stop", 4'h0, 4'h0, 4'h0);

        // high == 0: output stays low, strobe still every period.
        set_cfg(0, 3, 0, 0);
        cyc("h0_load", 4'h0, 4'h0, 4'h0);
        en = 4'h1;
        for (int i = 0; i < 10; i++)
            cyc("high0", 4'h0, ch0(i >= 1 && (i - 1) % 3 == 0), 4'h0);
        en = 4'h0;
        cyc("h0_stop", 4'h0, 4'h0, 4'h0);

        // high == period: output constant high, strobe every 6.
        set_cfg(0, 6, 6, 0);
        cyc("hp_load", 4'h0, 4'h0, 4'h0);
        en = 4'h1;
        for (int i = 0; i < 14; i++)
            cyc("high_eq_period", ch0(i >= 1), ch0(i >= 1 && (i - 1) % 6 == 0), 4'h0);
        en = 4'h0;
        cyc("hp_stop", 4'h0, 4'h0, 4'h0);

        // period == 0: error while enabled, cleared by a valid load which restarts the channel.
        set_cfg(0, 0, 1, 0);
        cyc("p0_load", 4'h0, 4'h0, 4'h0);
        en = 4'h1;
        for (int i = 0; i < 11; i++) begin
            if (i == 4) set_cfg(0, 4, 1, 0);
            o = ch0(i >= 6 && (i - 6) % 4 == 0);
            cyc("period0", o, o, ch0(i < 4));
        end
        en = 4'h0;
        cyc("p0_stop", 4'h0, 4'h0, 4'h0);

        // Multichannel: 4/2 with phases 0..3 on a common enable, then stop ch2 only.
        for (int c = 0; c < NUM_CH; c++) set_cfg(c, 4, 2, c);
        cyc("multi_load", 4'h0, 4'h0, 4'h0);
        en = 4'hf;
        for (int i = 0; i < 18; i++) begin
            if (i == 12) en[2] = 1'b0;
            o = '0; s = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (!(c == 2 && i >= 12) && i >= 1 + c) begin
                    o[c] = ((i - 1 - c) % 4) < 2;
                    s[c] = ((i - 1 - c) % 4) == 0;
                end
            end
            cyc("multi", o, s, 4'h0);
        end

        // Asynchronous reset mid-run, while ch0 is driving high.
        #2 rst_n = 1'b0;
        #1 expect_now("rst_async", 4'h0, 4'h0, 4'h0);
        en = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc("rst_idle", 4'h0, 4'h0, 4'h0);

        // After reset the default config 2/1/0 applies.
        en = 4'h1;
        for (int i = 0; i < 6; i++) begin
            o = ch0(i >= 1 && (i - 1) % 2 == 0);
            cyc("rst_default", o, o, 4'h0);
        end
        en = 4'h0;
        cyc("final_stop", 4'h0, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
